// File: rtl/cpu_cfg_writer_pkg.sv
// Shared definitions for the CPU-to-fabric configuration writer:
// FSM state encoding and configuration word geometry.
package cpu_cfg_writer_pkg;

    localparam int CFG_WORD_W     = 32;
    localparam int GAP_CYCLES_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2,
        ST_FIN    = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/cfg_word_fifo.sv
// Synchronous word FIFO; full/empty distinguished by an extra pointer bit.
// Head is presented combinationally from the read pointer.
module cfg_word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush shares the reset path so an abort empties the buffer in one edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end else begin
                rd_ptr <= rd_ptr;
            end
        end
    end

    // Storage array; contents are only observed between a push and its pop, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_cfg_writer.sv
// Streams CPU-buffered configuration words to the fabric as single-cycle
// write strobes, with a fixed idle gap between consecutive strobes.
module cpu_cfg_writer
    import cpu_cfg_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  cpu_wr_valid,
    input  logic [CFG_WORD_W-1:0] cpu_wr_data,
    output logic                  cpu_wr_ready,
    input  logic                  cpu_start,
    input  logic [15:0]           cpu_word_count,
    input  logic                  cpu_abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [15:0]           words_sent,
    output logic                  WriteStrobe,
    output logic [CFG_WORD_W-1:0] WriteData
);

    // Gap counter is loaded with GAP_CYCLES-1 so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    cfg_state_e            state;
    cfg_state_e            state_next;
    logic [15:0]           remaining;
    logic [15:0]           remaining_next;
    logic [15:0]           words_sent_next;
    logic [3:0]            gap_cnt;
    logic [3:0]            gap_cnt_next;
    logic                  strobe_next;
    logic [CFG_WORD_W-1:0] data_next;
    logic                  done_next;
    logic                  aborted_next;
    logic                  busy_next;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_flush;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CFG_WORD_W-1:0] fifo_head;

    assign cpu_wr_ready = !fifo_full;
    assign fifo_push    = cpu_wr_valid && !fifo_full && !cpu_abort;

    cfg_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CFG_WORD_W)
    ) u_fifo (
        .clk       (CLK),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (cpu_wr_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        state_next      = state;
        remaining_next  = remaining;
        words_sent_next = words_sent;
        gap_cnt_next    = gap_cnt;
        strobe_next     = 1'b0;
        data_next       = WriteData;
        done_next       = 1'b0;
        aborted_next    = 1'b0;
        fifo_pop        = 1'b0;
        fifo_flush      = 1'b0;
        if (cpu_abort) begin
            state_next   = ST_IDLE;
            fifo_flush   = 1'b1;
            aborted_next = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_start) begin
                        remaining_next  = cpu_word_count;
                        words_sent_next = 16'd0;
                        state_next      = (cpu_word_count == 16'd0) ? ST_FIN : ST_STREAM;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (!fifo_empty) begin
                        fifo_pop        = 1'b1;
                        strobe_next     = 1'b1;
                        data_next       = fifo_head;
                        remaining_next  = remaining - 16'd1;
                        words_sent_next = words_sent + 16'd1;
                        if (remaining == 16'd1) begin
                            state_next = ST_FIN;
                        end else if (GAP_CYCLES == 0) begin
                            state_next = ST_STREAM;
                        end else begin
                            state_next   = ST_GAP;
                            gap_cnt_next = GAP_LOAD;
                        end
                    end else begin
                        state_next = ST_STREAM;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state_next = ST_STREAM;
                    end else begin
                        gap_cnt_next = gap_cnt - 4'd1;
                    end
                end
                ST_FIN: begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
        busy_next = (state_next != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= ST_IDLE;
            remaining   <= 16'd0;
            words_sent  <= 16'd0;
            gap_cnt     <= 4'd0;
            WriteStrobe <= 1'b0;
            WriteData   <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            remaining   <= remaining_next;
            words_sent  <= words_sent_next;
            gap_cnt     <= gap_cnt_next;
            WriteStrobe <= strobe_next;
            WriteData   <= data_next;
            done        <= done_next;
            aborted     <= aborted_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: doc/cpu_cfg_writer.md
CPU_CFG_WRITER -- requirements
Module: cpu_cfg_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, word-buffer depth; power of two, at least 2.
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles forced between consecutive WriteStrobe pulses; range 0..15.
REQ-003 CLK  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_wr_valid  in  1  CPU offers a configuration word.
REQ-006 cpu_wr_data  in  32  configuration word.
REQ-007 cpu_wr_ready  out  1  FIFO can accept a word.
REQ-008 cpu_start  in  1  single-cycle pulse that begins a transfer.
REQ-009 cpu_word_count  in  16  number of words to send; sampled with cpu_start.
REQ-010 cpu_abort  in  1  single-cycle pulse that cancels the transfer and flushes the FIFO.
REQ-011 busy  out  1  a transfer is in progress.
REQ-012 done  out  1  one-cycle pulse when a transfer completes.
REQ-013 aborted  out  1  one-cycle pulse when an abort has been taken.
REQ-014 words_sent  out  16  count of strobes issued in the current or last transfer.
REQ-015 WriteStrobe  out  1  fabric configuration write strobe; registered.
REQ-016 WriteData  out  32  fabric configuration data; registered.

Function
REQ-017 A push occurs when cpu_wr_valid and cpu_wr_ready are both high; cpu_wr_ready SHALL equal "FIFO not full", with no bypass when full.
REQ-018 Pushes SHALL be accepted in every state, including IDLE, so the CPU can pre-load words.
REQ-019 FSM states are IDLE, STREAM, GAP, FIN.
REQ-020 IDLE with cpu_start: the block latches cpu_word_count into remaining, clears words_sent, and goes to STREAM; if the count is 0 it goes to FIN instead.
REQ-021 STREAM with FIFO non-empty: at the next edge WriteStrobe is 1, WriteData is the FIFO head, the head is popped, remaining decrements, and words_sent increments.
- The next state is FIN when remaining reaches 0.
- Otherwise the next state is GAP, or stays STREAM when GAP_CYCLES = 0.
REQ-022 STREAM with FIFO empty: the block holds with WriteStrobe 0 and busy 1 (underflow stall), with no timeout.
REQ-023 GAP holds WriteStrobe 0 for exactly GAP_CYCLES cycles, then returns to STREAM.
- Minimum strobe period is 1 + GAP_CYCLES.
REQ-024 WriteStrobe SHALL be high for exactly one cycle per word; WriteData holds its last value between strobes.
REQ-025 FIN asserts done for one cycle, then goes to IDLE.
REQ-026 Latency: cpu_start at edge t with a non-empty FIFO gives the first WriteStrobe high in the cycle after edge t+1.
REQ-027 busy = 1 in STREAM, GAP and FIN; 0 in IDLE.
REQ-028 cpu_start while not IDLE SHALL be ignored.
REQ-029 cpu_abort in any state SHALL, at the next edge:
- empty the FIFO;
- force IDLE and WriteStrobe 0;
- pulse aborted;
- not pulse done.
cpu_abort has priority over a simultaneous cpu_start or push.
REQ-030 A simultaneous push and pop SHALL keep occupancy unchanged.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-032 Words left in the FIFO after done remain available to the next transfer.

Reset
REQ-033 On reset the block SHALL:
- enter IDLE and empty the FIFO;
- drive WriteStrobe 0, WriteData 0, busy 0, done 0, aborted 0, words_sent 0;
- drive cpu_wr_ready 1.
REQ-034 Reset mid-transfer SHALL take effect at the next edge with no further strobe.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the 32-bit config word width constant, and the GAP_CYCLES maximum.
REQ-036 The FIFO SHALL be one sub-module, cfg_word_fifo (synchronous, parameterised by depth and width); the FSM stays in cpu_cfg_writer.

Verification
REQ-037 Preload 0xA5A5_0001..0xA5A5_0004, start with count 4, GAP=2: expect four 1-cycle strobes, 3 cycles apart, data in order, then a done pulse, words_sent=4, busy low.
REQ-038 Start with count 3 and an empty FIFO; push one word every 10 cycles: expect each strobe 1 cycle after the push is visible, and done after the third.
REQ-039 Push 9 words with FIFO_DEPTH=8 and no start: expect cpu_wr_ready low after 8 and the 9th word held off; start with count 9 and the 9th word is accepted after the first pop.
REQ-040 Abort after the second of 5 strobes: expect no further strobes, aborted pulse, no done, FIFO empty, cpu_wr_ready 1.
REQ-041 Start with count 0: expect done one cycle after FIN entry and no strobe; cpu_start while busy leaves remaining unchanged.
REQ-042 Assert reset during GAP: expect outputs at reset values next cycle and no strobe after.
